// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decoder/pipeline <-> hazard scoreboard signals; counter ports exist only with HAZARD_STALL_CNT_EN.
interface hazard_scoreboard_if #(parameter int RA_W = 5);
   logic [RA_W-1:0] d_rs, d_rt, d_wa;
   logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
   logic d_md, e_md_start, e_md_div, flush_e;
   logic stall, pc_en, d_en, e_clr, fwd_rt_m, md_busy;
   logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stall_cnt, md_stall_cnt;
`endif
   modport master (
      output d_rs, d_rt, d_wa, d_tuse_rs, d_tuse_rt, d_tnew, d_md, e_md_start, e_md_div, flush_e,
      input stall, pc_en, d_en, e_clr, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
`ifdef HAZARD_STALL_CNT_EN
      , stall_cnt, md_stall_cnt
`endif
   );
   modport slave (
      input d_rs, d_rt, d_wa, d_tuse_rs, d_tuse_rt, d_tnew, d_md, e_md_start, e_md_div, flush_e,
      output stall, pc_en, d_en, e_clr, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
`ifdef HAZARD_STALL_CNT_EN
      , stall_cnt, md_stall_cnt
`endif
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: Tuse/Tnew stall and forwarding control with MD busy counter.
// Optional stall statistics counters under HAZARD_STALL_CNT_EN.
module hazard_scoreboard #(
   parameter int RA_W = 5,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES = 10,
   parameter int CNT_W = 4
) (
   input logic clk,
   input logic reset,
   hazard_scoreboard_if.slave hz
);
   logic [RA_W-1:0] rs_e, rt_e, wa_e, rt_m, wa_m, wa_w;
   logic [1:0] tnew_e, tnew_m;
   logic [CNT_W-1:0] cnt;
   logic hz_stall, md_stall, e_clr;

   function automatic logic src_stall(input logic [RA_W-1:0] r, input logic [1:0] tuse);
      return r != '0 && tuse != 2'd3 && ((r == wa_e && tnew_e > tuse) || (r == wa_m && tnew_m > tuse));
   endfunction

   // nearest matching producer decides; a not-yet-ready producer yields 0 and the stall covers it
   function automatic logic [1:0] fwd_d(input logic [RA_W-1:0] r);
      return r == '0 ? 2'd0 : r == wa_e ? (tnew_e == '0 ? 2'd1 : 2'd0) :
             r == wa_m ? (tnew_m == '0 ? 2'd2 : 2'd0) : r == wa_w ? 2'd3 : 2'd0;
   endfunction

   function automatic logic [1:0] fwd_e(input logic [RA_W-1:0] r);
      return r == '0 ? 2'd0 : r == wa_m ? (tnew_m == '0 ? 2'd2 : 2'd0) : r == wa_w ? 2'd3 : 2'd0;
   endfunction

   always_comb begin
      md_stall = hz.d_md && (cnt != '0 || hz.e_md_start);
      hz_stall = src_stall(hz.d_rs, hz.d_tuse_rs) || src_stall(hz.d_rt, hz.d_tuse_rt) || md_stall;
      e_clr = hz_stall || hz.flush_e;
      hz.stall = hz_stall;
      hz.pc_en = !hz_stall;
      hz.d_en = !hz_stall;
      hz.e_clr = e_clr;
      hz.fwd_rs_d = fwd_d(hz.d_rs);
      hz.fwd_rt_d = fwd_d(hz.d_rt);
      hz.fwd_rs_e = fwd_e(rs_e);
      hz.fwd_rt_e = fwd_e(rt_e);
      hz.fwd_rt_m = rt_m != '0 && rt_m == wa_w;
      hz.md_busy = cnt != '0;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rs_e <= '0;
         rt_e <= '0;
         wa_e <= '0;
         tnew_e <= '0;
         rt_m <= '0;
         wa_m <= '0;
         tnew_m <= '0;
         wa_w <= '0;
         cnt <= '0;
      end else begin
         rs_e <= e_clr ? '0 : hz.d_rs;
         rt_e <= e_clr ? '0 : hz.d_rt;
         wa_e <= e_clr ? '0 : hz.d_wa;
         tnew_e <= e_clr ? '0 : hz.d_tnew;
         rt_m <= rt_e;
         wa_m <= wa_e;
         tnew_m <= tnew_e == '0 ? 2'd0 : tnew_e - 2'd1;
         wa_w <= wa_m;
         cnt <= hz.e_md_start ? (hz.e_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)) :
                cnt != '0 ? cnt - 1'b1 : cnt;
      end

`ifdef HAZARD_STALL_CNT_EN
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         hz.stall_cnt <= '0;
         hz.md_stall_cnt <= '0;
      end else begin
         if (hz_stall && !(&hz.stall_cnt)) hz.stall_cnt <= hz.stall_cnt + 32'd1;
         if (md_stall && !(&hz.md_stall_cnt)) hz.md_stall_cnt <= hz.md_stall_cnt + 32'd1;
      end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed test-plan scenarios plus random traffic against a stage-array reference model.
module tb_hazard_scoreboard;
   localparam int MULT = 5, DIV = 10;
   logic clk = 1'b0, reset;
   always #5 clk = ~clk;

   hazard_scoreboard_if #(.RA_W(5)) hz();
   hazard_scoreboard #(.RA_W(5), .MULT_CYCLES(MULT), .DIV_CYCLES(DIV), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .hz(hz));

   typedef struct {logic [4:0] rs, rt, wa; int tnew;} rec_t;
   rec_t pipe [3];
   int cyc, busy_until, errors = 0, checks = 0;
   longint stall_total, md_total, s0, m0;

   // readiness at stage i: cycles left after i stages spent since entering E
   function automatic int tn(int i);
      return pipe[i].tnew > i ? pipe[i].tnew - i : 0;
   endfunction
   function automatic bit m_busy();
      return cyc <= busy_until;
   endfunction
   function automatic bit src_hz(logic [4:0] r, int tuse);
      if (r == 0 || tuse == 3) return 0;
      for (int i = 0; i < 2; i++) if (pipe[i].wa == r && tn(i) > tuse) return 1;
      return 0;
   endfunction
   function automatic bit m_md();
      return hz.d_md && (m_busy() || hz.e_md_start);
   endfunction
   function automatic bit m_stall();
      return src_hz(hz.d_rs, int'(hz.d_tuse_rs)) || src_hz(hz.d_rt, int'(hz.d_tuse_rt)) || m_md();
   endfunction
   function automatic int m_fwd(logic [4:0] r, int first);
      if (r == 0) return 0;
      for (int i = first; i < 3; i++) if (pipe[i].wa == r) return tn(i) == 0 ? i + 1 : 0;
      return 0;
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
      cyc = 0;
      busy_until = -1;
      stall_total = 0;
      md_total = 0;
   endtask

   task automatic settle();
      bit st;
      #1;
      st = m_stall();
      chk("stall", hz.stall, st);
      chk("pc_en", hz.pc_en, !st);
      chk("d_en", hz.d_en, !st);
      chk("e_clr", hz.e_clr, st || hz.flush_e);
      chk("fwd_rs_d", hz.fwd_rs_d, m_fwd(hz.d_rs, 0));
      chk("fwd_rt_d", hz.fwd_rt_d, m_fwd(hz.d_rt, 0));
      chk("fwd_rs_e", hz.fwd_rs_e, m_fwd(pipe[0].rs, 1));
      chk("fwd_rt_e", hz.fwd_rt_e, m_fwd(pipe[0].rt, 1));
      chk("fwd_rt_m", hz.fwd_rt_m, pipe[1].rt != 0 && pipe[1].rt == pipe[2].wa);
      chk("md_busy", hz.md_busy, m_busy());
`ifdef HAZARD_STALL_CNT_EN
      chk("stall_cnt", hz.stall_cnt, stall_total[31:0]);
      chk("md_stall_cnt", hz.md_stall_cnt, md_total[31:0]);
`endif
   endtask

   task automatic clock();
      rec_t n;
      bit st;
      st = m_stall();
      n = '{default: 0};
      if (!(st || hz.flush_e)) n = '{hz.d_rs, hz.d_rt, hz.d_wa, int'(hz.d_tnew)};
      if (st) stall_total++;
      if (m_md()) md_total++;
      if (hz.e_md_start) busy_until = cyc + (hz.e_md_div ? DIV : MULT);
      @(posedge clk);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = n;
      cyc++;
      #1;
   endtask

   task automatic step();
      settle();
      clock();
   endtask

   task automatic set_d(int rs, int rt, int trs, int trt, int wa, int tnew, bit md);
      hz.d_rs = 5'(rs);
      hz.d_rt = 5'(rt);
      hz.d_tuse_rs = 2'(trs);
      hz.d_tuse_rt = 2'(trt);
      hz.d_wa = 5'(wa);
      hz.d_tnew = 2'(tnew);
      hz.d_md = md;
   endtask

   initial begin
      reset = 1'b1;
      set_d(0, 0, 3, 3, 0, 0, 0);
      hz.e_md_start = 1'b0;
      hz.e_md_div = 1'b0;
      hz.flush_e = 1'b0;
      model_reset();
      #1;
      settle();
      chk("reset_stall", hz.stall, 0);
      chk("reset_pc_en", hz.pc_en, 1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      // load then use
      set_d(0, 0, 3, 3, 8, 2, 0); step();
      set_d(8, 0, 1, 3, 9, 1, 0); settle();
      chk("lu_stall", hz.stall, 1);
      chk("lu_eclr", hz.e_clr, 1);
      clock();
      settle();
      chk("lu_release", hz.stall, 0);
      clock();
      set_d(0, 0, 3, 3, 0, 0, 0); settle();
      chk("lu_fwd_e_w", hz.fwd_rs_e, 3);
      clock();
      // ALU then branch
      set_d(0, 0, 3, 3, 5, 1, 0); step();
      set_d(5, 0, 0, 3, 0, 0, 0); settle();
      chk("br_stall", hz.stall, 1);
      clock();
      settle();
      chk("br_release", hz.stall, 0);
      chk("br_fwd_m", hz.fwd_rs_d, 2);
      clock();
      // jal then jr $31
      set_d(0, 0, 3, 3, 31, 0, 0); step();
      set_d(31, 0, 0, 3, 0, 0, 0); settle();
      chk("jr_stall", hz.stall, 0);
      chk("jr_fwd_e", hz.fwd_rs_d, 1);
      clock();
      // register zero and priority
      set_d(0, 0, 3, 3, 0, 2, 0); step(); step();
      set_d(0, 0, 0, 0, 0, 0, 0); settle();
      chk("r0_stall", hz.stall, 0);
      chk("r0_fwd_rs", hz.fwd_rs_d, 0);
      chk("r0_fwd_rt", hz.fwd_rt_d, 0);
      clock();
      set_d(0, 0, 3, 3, 7, 1, 0); step();
      set_d(0, 0, 3, 3, 7, 0, 0); step();
      set_d(7, 0, 0, 3, 0, 0, 0); settle();
      chk("prio_stall", hz.stall, 0);
      chk("prio_fwd", hz.fwd_rs_d, 1);
      clock();
      // divide then mflo
      set_d(0, 0, 3, 3, 0, 0, 0); step();
      s0 = stall_total;
      m0 = md_total;
      hz.e_md_start = 1'b1; hz.e_md_div = 1'b1; step();
      hz.e_md_start = 1'b0; set_d(0, 0, 3, 3, 0, 0, 1);
      for (int i = 0; i < DIV; i++) begin
         settle();
         chk("div_stall", hz.stall, 1);
         clock();
      end
      settle();
      chk("div_release", hz.stall, 0);
      chk("div_idle", hz.md_busy, 0);
`ifdef HAZARD_STALL_CNT_EN
      chk("div_stall_cnt", hz.stall_cnt, 32'(s0 + 10));
      chk("div_md_stall_cnt", hz.md_stall_cnt, 32'(m0 + 10));
`endif
      clock();
      // reset in the middle of a divide
      set_d(0, 0, 3, 3, 0, 0, 0);
      hz.e_md_start = 1'b1; hz.e_md_div = 1'b1; step();
      hz.e_md_start = 1'b0; set_d(0, 0, 3, 3, 0, 0, 1);
      step(); step(); step();
      settle();
      chk("pre_reset_stall", hz.stall, 1);
      reset = 1'b1;
      #1;
      chk("rst_md_busy", hz.md_busy, 0);
      chk("rst_stall", hz.stall, 0);
      chk("rst_pc_en", hz.pc_en, 1);
      chk("rst_d_en", hz.d_en, 1);
      model_reset();
      reset = 1'b0;
      set_d(0, 0, 3, 3, 0, 0, 0);
      clock();
      // store data from W
      set_d(0, 0, 3, 3, 9, 2, 0); step();
      set_d(0, 9, 3, 2, 0, 0, 0); step();
      set_d(0, 0, 3, 3, 0, 0, 0); step();
      settle();
      chk("sw_fwd_m", hz.fwd_rt_m, 1);
      clock();
      // random traffic
      for (int k = 0; k < 400; k++) begin
         set_d($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 7), $urandom_range(0, 2), $urandom_range(0, 3) == 0);
         hz.e_md_start = $urandom_range(0, 7) == 0;
         hz.e_md_div = 1'($urandom_range(0, 1));
         hz.flush_e = $urandom_range(0, 7) == 0;
         step();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
